// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT datapath: frame geometry, the
// ingest/replay state encoding and the 4-bit bit-reversal helper.
package fft16_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } fft16_state_e;

    // Maps a natural index onto its decimation-in-time position.
    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] a);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = a[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft16_sample_ram.sv
// One-frame sample store: synchronous write, asynchronous read so the replay
// register can be loaded on the same edge the address is presented.
module fft16_sample_ram #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [WORD_SIZE-1:0] rd_data_o
);

    // Contents are intentionally left unreset; every frame rewrites all entries.
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft16_input_reorder.sv
// Frame buffer at the head of the 16-point FFT: ingests 16 natural-order
// samples, then replays them in bit-reversed order on a registered stream.
module fft16_input_reorder
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int N_POINTS  = FFT_N
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WORD_SIZE-1:0] o_data,
    output logic [3:0]           o_index,
    output logic                 o_last,
    input  logic                 i_ready
);

    localparam int ADDR_W = FFT_LOG2N;
    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(N_POINTS - 1);

    fft16_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [ADDR_W-1:0]    index_q, index_d;

    logic                 wr_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 accept;
    logic                 deliver;

    assign o_ready = (state_q == ST_FILL);
    assign accept  = i_valid & o_ready;
    assign deliver = valid_q & i_ready;

    // rd_cnt_q is 0 throughout FILL, so the same address also serves the first load.
    assign rd_addr = bitrev4(rd_cnt_q);
    assign wr_en   = accept & ~i_flush;

    fft16_sample_ram #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (N_POINTS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk_i     (i_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i (i_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        index_d  = index_q;

        if (i_flush) begin
            // Any coincident handshake is discarded; data/index keep their last value.
            state_d  = ST_FILL;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (wr_cnt_q == CNT_MAX) begin
                            wr_cnt_d = '0;
                            state_d  = ST_DRAIN;
                            data_d   = rd_data;
                            index_d  = rd_addr;
                            valid_d  = 1'b1;
                            last_d   = 1'b0;
                            rd_cnt_d = ADDR_W'(1);
                        end else begin
                            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (deliver) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = ST_FILL;
                        end else begin
                            data_d   = rd_data;
                            index_d  = rd_addr;
                            last_d   = (rd_cnt_q == CNT_MAX);
                            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            index_q  <= index_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_index = index_q;
    assign o_last  = last_q;

endmodule
